// File: rtl/signal_pkg.sv
// Shared light codes and controller state encoding for the highway/country
// signal phase scheduler.
package signal_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    ALL_RED1    = 3'd2,
    CTRY_GREEN  = 3'd3,
    CTRY_YELLOW = 3'd4,
    ALL_RED2    = 3'd5
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Elapsed-cycles-in-phase counter: cleared on a phase change, saturates at all-ones.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/signal_phase_scheduler.sv
// Highway/country traffic-light phase scheduler with minimum/maximum green dwell.
// Define PED_REQ_EN to enable pedestrian requests and the walk indication.
module signal_phase_scheduler
  import signal_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_CTRY  = 8,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] contry,
  output logic       walk,
  output logic [2:0] phase
);

  generate
    if (T_MIN_GREEN < 1 || T_MAX_CTRY < 1 || T_YELLOW < 1 || T_ALLRED < 1 ||
        T_MAX_CTRY < T_MIN_GREEN || CNT_W < 1 || CNT_W > 31 ||
        T_MAX_CTRY >= (1 << CNT_W) || T_MIN_GREEN >= (1 << CNT_W) ||
        T_YELLOW >= (1 << CNT_W) || T_ALLRED >= (1 << CNT_W)) begin : g_param_error
      $error("signal_phase_scheduler: illegal timing parameters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] L_MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_MAX_LAST = CNT_W'(T_MAX_CTRY - 1);
  localparam logic [CNT_W-1:0] L_YEL_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_AR_LAST  = CNT_W'(T_ALLRED - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] w_e;
  logic             w_state_change;
  logic             w_ped_pending;
  logic             w_demand;
  logic             r_x_meta;
  logic             r_x_s;

  // The country sensor is asynchronous; only the second flop feeds the FSM.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_x_meta <= 1'b0;
      r_x_s    <= 1'b0;
    end else begin
      r_x_meta <= x;
      r_x_s    <= r_x_meta;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= HWY_GREEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_demand = r_x_s | w_ped_pending;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HWY_GREEN:   if ((w_e >= L_MIN_LAST) && w_demand) w_state_next = HWY_YELLOW;
      HWY_YELLOW:  if (w_e == L_YEL_LAST) w_state_next = ALL_RED1;
      ALL_RED1:    if (w_e == L_AR_LAST) w_state_next = CTRY_GREEN;
      CTRY_GREEN:  if (((w_e >= L_MIN_LAST) && !r_x_s) || (w_e == L_MAX_LAST))
                     w_state_next = CTRY_YELLOW;
      CTRY_YELLOW: if (w_e == L_YEL_LAST) w_state_next = ALL_RED2;
      ALL_RED2:    if (w_e == L_AR_LAST) w_state_next = HWY_GREEN;
      default:     w_state_next = HWY_GREEN;
    endcase
  end

  // Any state change, including recovery from an illegal code, restarts the count.
  assign w_state_change = (w_state_next != r_state);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .clr_n    (clr_n),
    .i_clear  (w_state_change),
    .i_enable (1'b1),
    .o_count  (w_e)
  );

  always_comb begin
    hwy    = RED;
    contry = RED;
    case (r_state)
      HWY_GREEN:   hwy    = GREEN;
      HWY_YELLOW:  hwy    = YELLOW;
      CTRY_GREEN:  contry = GREEN;
      CTRY_YELLOW: contry = YELLOW;
      default: begin
        hwy    = RED;
        contry = RED;
      end
    endcase
  end

  assign phase = r_state;

`ifdef PED_REQ_EN
  logic w_enter_ctry;
  logic r_ped_pending;
  logic r_walk;

  assign w_enter_ctry = (w_state_next == CTRY_GREEN) && (r_state != CTRY_GREEN);

  // Entering country green consumes the request; the walk flag lasts that visit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
    end else begin
      if (w_enter_ctry) begin
        r_ped_pending <= 1'b0;
      end else if (ped_req) begin
        r_ped_pending <= 1'b1;
      end
      if (w_enter_ctry) begin
        r_walk <= r_ped_pending;
      end else if (w_state_next != CTRY_GREEN) begin
        r_walk <= 1'b0;
      end
    end
  end

  assign w_ped_pending = r_ped_pending;
  assign walk          = r_walk;
`else
  logic w_unused_ped_req;

  assign w_unused_ped_req = ped_req;
  assign w_ped_pending    = 1'b0;
  assign walk             = 1'b0;
`endif

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed self-checking bench for signal_phase_scheduler (default timing parameters);
// follows PED_REQ_EN the same way the design does.
module tb_signal_phase_scheduler;
  import signal_pkg::*;

  logic       clk     = 1'b0;
  logic       clr_n   = 1'b1;
  logic       x       = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] hwy;
  logic [1:0] contry;
  logic       walk;
  logic [2:0] phase;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signal_phase_scheduler dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .x       (x),
    .ped_req (ped_req),
    .hwy     (hwy),
    .contry  (contry),
    .walk    (walk),
    .phase   (phase)
  );

  // Expected {hwy, contry} for a phase code, from the light table.
  function automatic logic [3:0] exp_lights(input logic [2:0] p);
    case (p)
      3'd0:    return 4'b10_00;
      3'd1:    return 4'b01_00;
      3'd3:    return 4'b00_10;
      3'd4:    return 4'b00_01;
      default: return 4'b00_00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a clock edge with reset just released (cycle 0).
  task automatic apply_reset();
    clr_n   = 1'b0;
    x       = 1'b0;
    ped_req = 1'b0;
    #1;
    repeat (2) tick();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 clr_n = 1'b0;
    #1;
    n_vec++;
    if (phase !== 3'd0 || hwy !== 2'b10 || contry !== 2'b00 || walk !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: got phase=%0d hwy=%b contry=%b walk=%b, want 0/10/00/0",
               phase, hwy, contry, walk);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (phase !== 3'd0 || hwy !== 2'b10 || contry !== 2'b00 || walk !== 1'b0) begin
        n_err++;
        $display("FAIL reset_held cyc%0d: got phase=%0d hwy=%b contry=%b walk=%b, want 0/10/00/0",
                 i, phase, hwy, contry, walk);
      end
    end
    clr_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_vec++;
      if (phase !== 3'd0 || hwy !== 2'b10 || contry !== 2'b00 || walk !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: got phase=%0d hwy=%b contry=%b walk=%b, want 0/10/00/0",
                 i + 1, phase, hwy, contry, walk);
      end
    end
    $display("test_reset: async assert, 3 cycles held, 50 idle cycles checked");
  endtask

  task automatic test_x_held();
    int         exp_p [21] = '{0,0,1,1,2,3,3,3,3,3,3,3,3,4,4,5,0,0,0,0,1};
    logic [2:0] ep;
    logic [3:0] lt;
    apply_reset();
    repeat (10) tick();
    x = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      ep = 3'(exp_p[i]);
      lt = exp_lights(ep);
      n_vec++;
      if (phase !== ep || hwy !== lt[3:2] || contry !== lt[1:0] || walk !== 1'b0) begin
        n_err++;
        $display("FAIL x_held cyc%0d: got phase=%0d hwy=%b contry=%b walk=%b, want %0d/%b/%b/0",
                 i + 11, phase, hwy, contry, walk, ep, lt[3:2], lt[1:0]);
      end
    end
    x = 1'b0;
    $display("test_x_held: 21 cycles checked (max country dwell)");
  endtask

  task automatic test_min_green();
    int         exp_p [18] = '{0,0,1,1,2,3,3,3,3,4,4,5,0,0,0,0,0,0};
    logic [2:0] ep;
    logic [3:0] lt;
    // Synchronized pulse lands on e=2: not enough green yet, and it vanishes.
    apply_reset();
    x = 1'b1;
    tick();
    x = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (phase !== 3'd0 || hwy !== 2'b10) begin
        n_err++;
        $display("FAIL short_pulse cyc%0d: got phase=%0d hwy=%b, want 0/10", i + 1, phase, hwy);
      end
      tick();
    end
    // Synchronized pulse lands on e=3: exits, country green runs minimum dwell.
    apply_reset();
    tick();
    x = 1'b1;
    tick();
    x = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ep = 3'(exp_p[i]);
      lt = exp_lights(ep);
      n_vec++;
      if (phase !== ep || hwy !== lt[3:2] || contry !== lt[1:0]) begin
        n_err++;
        $display("FAIL x_pulse cyc%0d: got phase=%0d hwy=%b contry=%b, want %0d/%b/%b",
                 i + 2, phase, hwy, contry, ep, lt[3:2], lt[1:0]);
      end
      tick();
    end
    $display("test_min_green: short pulse ignored, e=3 pulse gives 4-cycle country green");
  endtask

  task automatic test_reset_mid_yellow();
    int exp_p [4] = '{0,0,0,1};
    apply_reset();
    x = 1'b1;
    for (int i = 0; i < 40 && phase !== 3'd4; i++) tick();
    n_vec++;
    if (phase !== 3'd4) begin
      n_err++;
      $display("FAIL reach_ctry_yellow: got phase=%0d, want 4 within 40 cycles", phase);
    end
    #2 clr_n = 1'b0;
    #1;
    n_vec++;
    if (phase !== 3'd0 || hwy !== 2'b10 || contry !== 2'b00) begin
      n_err++;
      $display("FAIL reset_in_yellow: got phase=%0d hwy=%b contry=%b, want 0/10/00",
               phase, hwy, contry);
    end
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (phase !== 3'(exp_p[i])) begin
        n_err++;
        $display("FAIL post_reset_min_green cyc%0d: got phase=%0d, want %0d",
                 i + 1, phase, exp_p[i]);
      end
    end
    x = 1'b0;
    $display("test_reset_mid_yellow: immediate reset, min green re-enforced");
  endtask

  task automatic test_ped();
`ifdef PED_REQ_EN
    int   exp_p [20] = '{0,0,0,1,1,2,3,3,3,3,4,4,5,0,0,0,0,0,0,0};
`else
    int   exp_p [20] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
`endif
    logic [2:0] ep;
    logic       ew;
    apply_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ep = 3'(exp_p[i]);
`ifdef PED_REQ_EN
      ew = (ep == 3'd3);
`else
      ew = 1'b0;
`endif
      n_vec++;
      if (phase !== ep || walk !== ew) begin
        n_err++;
        $display("FAIL ped cyc%0d: got phase=%0d walk=%b, want %0d/%b", i + 1, phase, walk, ep, ew);
      end
      ped_req = (i == 3);
      tick();
    end
    ped_req = 1'b0;
    $display("test_ped: 20 cycles checked, repeat request in highway yellow");
  endtask

  task automatic test_illegal_state();
    int exp_p [5] = '{0,0,0,0,1};
    logic [3:0] lt;
    apply_reset();
    repeat (5) tick();
    force dut.r_state = state_t'(3'd7);
    x = 1'b1;
    #3;
    release dut.r_state;
    for (int i = 0; i < 5; i++) begin
      tick();
      lt = exp_lights(3'(exp_p[i]));
      n_vec++;
      if (phase !== 3'(exp_p[i]) || hwy !== lt[3:2] || contry !== lt[1:0]) begin
        n_err++;
        $display("FAIL illegal_recover cyc%0d: got phase=%0d hwy=%b contry=%b, want %0d/%b/%b",
                 i + 6, phase, hwy, contry, exp_p[i], lt[3:2], lt[1:0]);
      end
    end
    x = 1'b0;
    $display("test_illegal_state: code 7 recovers to highway green with fresh count");
  endtask

  task automatic test_exclusion();
    apply_reset();
    x = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_vec++;
      if ((hwy !== 2'b00 && contry !== 2'b00) || hwy === 2'b11 || contry === 2'b11) begin
        n_err++;
        $display("FAIL exclusion cyc%0d: got hwy=%b contry=%b, want one RED and legal codes",
                 i + 1, hwy, contry);
      end
    end
    x = 1'b0;
    $display("test_exclusion: 60 cycles of continuous demand checked");
  endtask

  initial begin
    test_reset();
    test_x_held();
    test_min_green();
    test_reset_mid_yellow();
    test_ped();
    test_illegal_state();
    test_exclusion();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
